// File: rtl/inst_cache.sv
// rtl/inst_cache.sv - direct-mapped read-only instruction cache
//
// Purpose:
//   One 32-bit word per line, 2**INDEX_BITS lines, tag = pc[31:INDEX_BITS+2].
//   Hits answer one cycle after the request is sampled. Misses raise
//   fetch_enable/inst_addr to the memory controller until mem_valid, then
//   install the returned word and forward it unless a flush cancelled it.
//   Optional feature macro: ICACHE_STAT_EN adds hit_cnt/miss_cnt outputs.
//
// Ports:
//   clk          in   clock, all state changes on posedge
//   rst_n        in   asynchronous active-low reset
//   rdy          in   global ready; 0 freezes all state and outputs
//   fetch_req    in   fetcher request (level)
//   pc           in   request address (pc[1:0] ignored)
//   flush        in   redirect; cancels the pending response
//   inst_valid   out  one-cycle pulse, inst holds the requested word
//   inst         out  instruction word
//   busy         out  high while a miss is outstanding
//   fetch_enable out  miss request to the memory controller
//   inst_addr    out  miss word address {pc[31:2],2'b00}
//   mem_valid    in   memory controller response strobe
//   mem_data     in   memory controller response data
//   hit_cnt      out  (ICACHE_STAT_EN) accepted hits, wraps
//   miss_cnt     out  (ICACHE_STAT_EN) IDLE->MISS transitions, wraps

module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic        busy,
  output logic        fetch_enable,
  output logic [31:0] inst_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic              fetch_enable_q, fetch_enable_d;
  logic [31:0]       inst_addr_q, inst_addr_d;
  logic              drop_q, drop_d;
  logic              install;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic                  req_ok;
  logic                  unused_pc_bits;

  assign req_idx  = pc[INDEX_BITS+1:2];
  assign req_tag  = pc[31:INDEX_BITS+2];
  // The miss address register doubles as the latched request for the refill.
  assign fill_idx = inst_addr_q[INDEX_BITS+1:2];
  assign fill_tag = inst_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_pc_bits = ^pc[1:0];

  // While inst_valid is out the fetcher still shows the request just served;
  // ignoring it that cycle keeps one pulse per presented request.
  assign req_ok = fetch_req && !flush && !inst_valid_q;

  always_comb begin
    state_d        = state_q;
    inst_valid_d   = 1'b0;
    inst_d         = inst_q;
    fetch_enable_d = fetch_enable_q;
    inst_addr_d    = inst_addr_q;
    drop_d         = drop_q;
    install        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_ok) begin
          if (hit) begin
            inst_d       = data_q[req_idx];
            inst_valid_d = 1'b1;
          end else begin
            fetch_enable_d = 1'b1;
            inst_addr_d    = {pc[31:2], 2'b00};
            state_d        = MISS;
          end
        end
      end
      MISS: begin
        if (mem_valid) begin
          // The refill always completes; only the forward is suppressed.
          install        = 1'b1;
          fetch_enable_d = 1'b0;
          drop_d         = 1'b0;
          state_d        = IDLE;
          if (!drop_q && !flush) begin
            inst_d       = mem_data;
            inst_valid_d = 1'b1;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      inst_valid_q   <= 1'b0;
      inst_q         <= 32'd0;
      fetch_enable_q <= 1'b0;
      inst_addr_q    <= 32'd0;
      drop_q         <= 1'b0;
      valid_q        <= '0;
    end else if (rdy) begin
      state_q        <= state_d;
      inst_valid_q   <= inst_valid_d;
      inst_q         <= inst_d;
      fetch_enable_q <= fetch_enable_d;
      inst_addr_q    <= inst_addr_d;
      drop_q         <= drop_d;
      if (install) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (rdy && install) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign busy         = (state_q != IDLE);
  assign fetch_enable = fetch_enable_q;
  assign inst_addr    = inst_addr_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        hit_evt;
  logic        miss_evt;

  assign hit_evt  = (state_q == IDLE) && req_ok && hit;
  assign miss_evt = (state_q == IDLE) && req_ok && !hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (rdy) begin
      if (hit_evt) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_evt) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// tb/tb_inst_cache.sv - self-checking bench for inst_cache

module tb_inst_cache;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        fetch_req;
  logic [31:0] pc;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic        busy;
  logic        fetch_enable;
  logic [31:0] inst_addr;
  logic        mem_valid;
  logic [31:0] mem_data;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .fetch_req    (fetch_req),
    .pc           (pc),
    .flush        (flush),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .busy         (busy),
    .fetch_enable (fetch_enable),
    .inst_addr    (inst_addr),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data)
`ifdef ICACHE_STAT_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the cache is a set of remembered word addresses, one per index,
  // plus at most one outstanding miss that may have been cancelled.
  bit          m_line_ok   [64];
  logic [29:0] m_line_word [64];
  logic [31:0] m_line_data [64];
  bit          m_miss_open;
  bit          m_cancel;
  logic [31:0] m_addr;
  logic        e_valid;
  logic [31:0] e_inst;
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_line_ok[i] = 1'b0;
    m_miss_open = 1'b0;
    m_cancel    = 1'b0;
    m_addr      = 32'd0;
    e_valid     = 1'b0;
    e_inst      = 32'd0;
    m_hits      = 0;
    m_misses    = 0;
  endtask

  task automatic model_step();
    logic prev_valid;
    int   i;
    prev_valid = e_valid;
    e_valid    = 1'b0;
    if (!m_miss_open) begin
      if (fetch_req && !flush && !prev_valid) begin
        i = idx_of(pc);
        if (m_line_ok[i] && m_line_word[i] == pc[31:2]) begin
          e_valid = 1'b1;
          e_inst  = m_line_data[i];
          m_hits++;
        end else begin
          m_miss_open = 1'b1;
          m_cancel    = 1'b0;
          m_addr      = {pc[31:2], 2'b00};
          m_misses++;
        end
      end
    end else if (mem_valid) begin
      i = idx_of(m_addr);
      m_line_ok[i]   = 1'b1;
      m_line_word[i] = m_addr[31:2];
      m_line_data[i] = mem_data;
      if (!m_cancel && !flush) begin
        e_valid = 1'b1;
        e_inst  = mem_data;
      end
      m_miss_open = 1'b0;
    end else if (flush) begin
      m_cancel = 1'b1;
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else if (rdy) model_step();
      #1;
      check("cyc_inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
      check("cyc_inst", inst, e_inst);
      check("cyc_fetch_enable", {31'd0, fetch_enable}, {31'd0, m_miss_open});
      check("cyc_busy", {31'd0, busy}, {31'd0, m_miss_open});
      check("cyc_inst_addr", inst_addr, m_addr);
`ifdef ICACHE_STAT_EN
      check("cyc_hit_cnt", hit_cnt, m_hits);
      check("cyc_miss_cnt", miss_cnt, m_misses);
`endif
    end
  end

  // Presents a request at a negedge and plays the memory controller,
  // answering a miss three cycles after fetch_enable first appears.
  task automatic fetch(input logic [31:0] a, input logic [31:0] fill,
                       output logic [31:0] got, output int lat, output bit missed);
    int wait_c;
    bit done;
    wait_c = 0;
    done   = 1'b0;
    got    = 32'd0;
    lat    = 0;
    missed = 1'b0;
    fetch_req = 1'b1;
    pc        = a;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (inst_valid) begin
        got       = inst;
        lat       = i + 1;
        done      = 1'b1;
        fetch_req = 1'b0;
      end else if (fetch_enable) begin
        missed = 1'b1;
        wait_c++;
        if (wait_c == 3) begin
          mem_valid = 1'b1;
          mem_data  = fill;
        end
      end
    end
    if (!done) begin
      check("fetch_timeout", 32'd0, 32'd1);
      fetch_req = 1'b0;
    end
  endtask

  logic [31:0] got;
  int          lat;
  bit          missed;

  initial begin : stimulus
    rst_n = 1'b0; rdy = 1'b1; fetch_req = 1'b0; pc = 32'd0; flush = 1'b0;
    mem_valid = 1'b0; mem_data = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_inst", inst, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Cold miss on 0x10.
    fetch_req = 1'b1; pc = 32'h0000_0010;
    @(negedge clk);
    check("t1_fetch_enable", {31'd0, fetch_enable}, 32'd1);
    check("t1_inst_addr", inst_addr, 32'h0000_0010);
    mem_valid = 1'b1; mem_data = 32'h0040_0093;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
    check("t1_inst", inst, 32'h0040_0093);
    check("t1_fe_low", {31'd0, fetch_enable}, 32'd0);
    fetch_req = 1'b0;
    @(negedge clk);

    // 2. Hit on 0x10, latency one cycle.
    fetch(32'h10, 32'hBAD0_0010, got, lat, missed);
    check("t2_missed", {31'd0, missed}, 32'd0);
    check("t2_lat", lat, 32'd1);
    check("t2_inst", got, 32'h0040_0093);
    @(negedge clk);

    // 3. Conflict: 0x110 shares index 4 with 0x10.
    fetch(32'h110, 32'hAAAA_0110, got, lat, missed);
    check("t3_missed_110", {31'd0, missed}, 32'd1);
    check("t3_inst_110", got, 32'hAAAA_0110);
    @(negedge clk);
    fetch(32'h10, 32'h0040_0093, got, lat, missed);
    check("t3_missed_10", {31'd0, missed}, 32'd1);
    check("t3_inst_10", got, 32'h0040_0093);
    @(negedge clk);

    // 4. Flush while a miss on 0x20 is outstanding.
    fetch_req = 1'b1; pc = 32'h20;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; fetch_req = 1'b0;
    @(negedge clk);
    flush = 1'b0; mem_valid = 1'b1; mem_data = 32'h1234_5678;
    @(negedge clk);
    mem_valid = 1'b0;
    check("t4_no_valid", {31'd0, inst_valid}, 32'd0);
    check("t4_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    fetch(32'h20, 32'hDEAD_BEEF, got, lat, missed);
    check("t4_missed", {31'd0, missed}, 32'd0);
    check("t4_inst", got, 32'h1234_5678);
    @(negedge clk);

    // Flush coinciding with mem_valid: installed, not forwarded.
    fetch_req = 1'b1; pc = 32'h30;
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b1; mem_valid = 1'b1; mem_data = 32'hC0DE_0030;
    @(negedge clk);
    flush = 1'b0; mem_valid = 1'b0;
    check("tfm_no_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'h30, 32'hBAD0_0030, got, lat, missed);
    check("tfm_missed", {31'd0, missed}, 32'd0);
    check("tfm_inst", got, 32'hC0DE_0030);
    @(negedge clk);

    // Flush in IDLE ignores the request that cycle.
    fetch_req = 1'b1; pc = 32'h10; flush = 1'b1;
    @(negedge clk);
    check("tfi_no_valid", {31'd0, inst_valid}, 32'd0);
    check("tfi_not_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0; fetch_req = 1'b0;
    @(negedge clk);

    // 5. rdy low for five cycles during a miss.
    fetch_req = 1'b1; pc = 32'h40;
    @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_fe_held", {31'd0, fetch_enable}, 32'd1);
      check("t5_addr_held", inst_addr, 32'h40);
      check("t5_busy_held", {31'd0, busy}, 32'd1);
    end
    rdy = 1'b1; mem_valid = 1'b1; mem_data = 32'h55AA_0040;
    @(negedge clk);
    mem_valid = 1'b0; fetch_req = 1'b0;
    check("t5_valid", {31'd0, inst_valid}, 32'd1);
    check("t5_inst", inst, 32'h55AA_0040);
    @(negedge clk);

    // rdy low holds an inst_valid pulse.
    fetch_req = 1'b1; pc = 32'h40;
    @(negedge clk);
    check("trdy_hit", {31'd0, inst_valid}, 32'd1);
    rdy = 1'b0; fetch_req = 1'b0;
    @(negedge clk);
    check("trdy_held", {31'd0, inst_valid}, 32'd1);
    rdy = 1'b1;
    @(negedge clk);
    check("trdy_cleared", {31'd0, inst_valid}, 32'd0);

    // 6. Asynchronous reset in the middle of a miss.
    fetch_req = 1'b1; pc = 32'h60;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_fe", {31'd0, fetch_enable}, 32'd0);
    check("t6_addr", inst_addr, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_valid", {31'd0, inst_valid}, 32'd0);
    fetch_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fetch(32'h10, 32'h0040_0093, got, lat, missed);
    check("t6_missed", {31'd0, missed}, 32'd1);
    check("t6_inst", got, 32'h0040_0093);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
